// File: rtl/muldiv_hilo_sequencer.sv
// EX-stage control beside the ALU/multiplier datapath: funct decode,
// MULTU sequencing with HI/LO write enable, and HI/LO hazard stall.
module muldiv_hilo_sequencer #(
  parameter int MUL_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_in,
  input  logic [5:0] funct,
  input  logic       flush,
  output logic [2:0] alu_ctrl,
  output logic [1:0] result_sel,
  output logic       mul_start,
  output logic       mul_busy,
  output logic       hilo_we,
  output logic       stall
);

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_BEQ   = 6'b000011;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULTU = 6'b011001;

  // Counter covers every MUL_RUN edge so hilo_we lands MUL_CYCLES edges
  // after acceptance.
  localparam logic [5:0] CNT_LOAD = 6'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL_RUN,
    MUL_WB
  } state_t;

  state_t     state;
  logic [5:0] cnt;
  logic       hilo_op;

  always_comb begin
    alu_ctrl   = 3'b010;
    result_sel = 2'b00;
    case (funct)
      F_AND:   alu_ctrl = 3'b000;
      F_OR:    alu_ctrl = 3'b001;
      F_ADD:   alu_ctrl = 3'b010;
      F_SUB:   alu_ctrl = 3'b110;
      F_BEQ:   alu_ctrl = 3'b110;
      F_SLT:   alu_ctrl = 3'b111;
      F_SLL:   result_sel = 2'b11;
      F_MFHI:  result_sel = 2'b01;
      F_MFLO:  result_sel = 2'b10;
      default: ;
    endcase
  end

  assign hilo_op  = (funct == F_MFHI) | (funct == F_MFLO)
                  | (funct == F_MULTU);
  assign mul_busy = (state != IDLE);
  assign stall    = valid_in & mul_busy & hilo_op;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      mul_start <= 1'b0;
      hilo_we   <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      mul_start <= 1'b0;
      hilo_we   <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      hilo_we   <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in && funct == F_MULTU) begin
            state     <= MUL_RUN;
            cnt       <= CNT_LOAD;
            mul_start <= 1'b1;
          end
        end
        MUL_RUN: begin
          if (cnt != 6'd0) begin
            cnt <= cnt - 6'd1;
          end else begin
            state   <= MUL_WB;
            hilo_we <= 1'b1;
          end
        end
        MUL_WB: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_sequencer.sv
// Bench for muldiv_hilo_sequencer: decode table, then multiply
// latency, stall, back-to-back, flush and reset sequences.
module tb_muldiv_hilo_sequencer;

  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] ADD   = 6'b100000;

  logic       clk = 1'b0;
  logic       reset, valid_in, flush;
  logic [5:0] funct;
  logic [2:0] alu_ctrl;
  logic [1:0] result_sel;
  logic       mul_start, mul_busy, hilo_we, stall;

  logic       v2;
  logic [5:0] f2;
  logic [2:0] alu2;
  logic [1:0] sel2;
  logic       start2, busy2, we2, stall2;

  int nvec = 0;
  int nbad = 0;
  int en = 0;
  int npulse = 0;
  int expq[$];

  always #5 clk = ~clk;

  muldiv_hilo_sequencer #(.MUL_CYCLES(32)) u_dut (
    .clk(clk), .reset(reset), .valid_in(valid_in),
    .funct(funct), .flush(flush), .alu_ctrl(alu_ctrl),
    .result_sel(result_sel), .mul_start(mul_start),
    .mul_busy(mul_busy), .hilo_we(hilo_we), .stall(stall)
  );

  muldiv_hilo_sequencer #(.MUL_CYCLES(2)) u_dut2 (
    .clk(clk), .reset(reset), .valid_in(v2),
    .funct(f2), .flush(flush), .alu_ctrl(alu2),
    .result_sel(sel2), .mul_start(start2),
    .mul_busy(busy2), .hilo_we(we2), .stall(stall2)
  );

  task automatic chk(string n, logic [7:0] act, logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s @edge %0d: got %0h want %0h", n, en, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every hilo_we pulse must match a queued edge number.
  initial begin
    forever begin
      @(posedge clk);
      en++;
      #1;
      if (hilo_we === 1'b1) begin
        npulse++;
        if (expq.size() == 0) begin
          chk("hilo_we_unexpected", 8'(hilo_we), 8'd0);
        end else begin
          chk("hilo_we_edge", 8'(en - expq.pop_front()), 8'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [5:0] f;
    logic [2:0] alu;
    logic [1:0] sel;
  } dvec_t;

  dvec_t tbl[12];
  int a;

  initial begin
    tbl[0]  = '{6'b100100, 3'b000, 2'b00};
    tbl[1]  = '{6'b100101, 3'b001, 2'b00};
    tbl[2]  = '{6'b100000, 3'b010, 2'b00};
    tbl[3]  = '{6'b100010, 3'b110, 2'b00};
    tbl[4]  = '{6'b000011, 3'b110, 2'b00};
    tbl[5]  = '{6'b101010, 3'b111, 2'b00};
    tbl[6]  = '{6'b000000, 3'b010, 2'b11};
    tbl[7]  = '{6'b010000, 3'b010, 2'b01};
    tbl[8]  = '{6'b010010, 3'b010, 2'b10};
    tbl[9]  = '{6'b011001, 3'b010, 2'b00};
    tbl[10] = '{6'b111111, 3'b010, 2'b00};
    tbl[11] = '{6'b001000, 3'b010, 2'b00};

    reset = 1'b1; valid_in = 1'b0; flush = 1'b0;
    funct = ADD; v2 = 1'b0; f2 = ADD;
    step(); step();
    chk("rst_start", 8'(mul_start), 8'd0);
    chk("rst_busy", 8'(mul_busy), 8'd0);
    chk("rst_we", 8'(hilo_we), 8'd0);
    chk("rst_stall", 8'(stall), 8'd0);
    reset = 1'b0;

    // Decode table; flush held so the MULTU entry is never accepted.
    flush = 1'b1; valid_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      funct = tbl[i].f;
      #1;
      chk($sformatf("alu_%b", tbl[i].f), 8'(alu_ctrl), 8'(tbl[i].alu));
      chk($sformatf("sel_%b", tbl[i].f), 8'(result_sel), 8'(tbl[i].sel));
      chk($sformatf("stall_%b", tbl[i].f), 8'(stall), 8'd0);
    end
    step();
    chk("flush_no_accept", 8'(mul_busy), 8'd0);
    flush = 1'b0; valid_in = 1'b0;
    step();

    // Latency, MFHI stall, interleaved ADD.
    valid_in = 1'b1; funct = MULTU;
    a = en + 1;
    expq.push_back(a + 32);
    step();
    chk("start_pulse", 8'(mul_start), 8'd1);
    chk("busy_e0", 8'(mul_busy), 8'd1);
    funct = MFHI;
    for (int k = 1; k <= 33; k++) begin
      step();
      chk($sformatf("busy_e%0d", k), 8'(mul_busy), 8'(k <= 32));
      chk($sformatf("stall_e%0d", k), 8'(stall), 8'(k <= 32));
      chk($sformatf("start_e%0d", k), 8'(mul_start), 8'd0);
      chk($sformatf("we_e%0d", k), 8'(hilo_we), 8'(k == 32));
      if (k == 10 || k == 32) begin
        funct = ADD;
        #1;
        chk($sformatf("add_stall_e%0d", k), 8'(stall), 8'd0);
        funct = MFHI;
        #1;
      end
    end
    chk("mfhi_sel", 8'(result_sel), 8'd1);
    valid_in = 1'b0;
    step();

    // Back-to-back MULTU.
    npulse = 0;
    valid_in = 1'b1; funct = MULTU;
    a = en + 1;
    expq.push_back(a + 32);
    step();
    while (en < a + 33) begin
      chk($sformatf("b2b_stall_e%0d", en - a), 8'(stall), 8'd1);
      chk($sformatf("b2b_start_e%0d", en - a), 8'(mul_start), 8'(en == a));
      step();
    end
    chk("b2b_idle_stall", 8'(stall), 8'd0);
    expq.push_back(en + 1 + 32);
    step();
    chk("b2b_second_start", 8'(mul_start), 8'd1);
    valid_in = 1'b0;
    repeat (34) step();
    chk("b2b_pulses", 8'(npulse), 8'd2);
    chk("b2b_idle", 8'(mul_busy), 8'd0);

    // Flush at cycle 10 aborts without a write.
    valid_in = 1'b1; funct = MULTU;
    step();
    valid_in = 1'b0;
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_busy", 8'(mul_busy), 8'd0);
    repeat (40) step();
    valid_in = 1'b1; funct = MULTU;
    a = en + 1;
    expq.push_back(a + 32);
    step();
    valid_in = 1'b0;
    repeat (32) step();
    chk("post_flush_busy32", 8'(mul_busy), 8'd1);
    step();
    chk("post_flush_idle33", 8'(mul_busy), 8'd0);

    // Reset at cycle 20 mid-multiply.
    valid_in = 1'b1; funct = MULTU;
    step();
    funct = MFHI;
    repeat (19) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid_busy", 8'(mul_busy), 8'd0);
    chk("rst_mid_start", 8'(mul_start), 8'd0);
    chk("rst_mid_we", 8'(hilo_we), 8'd0);
    chk("rst_mid_stall", 8'(stall), 8'd0);
    valid_in = 1'b0;
    repeat (20) step();

    // MUL_CYCLES = 2 instance.
    v2 = 1'b1; f2 = MULTU;
    step();
    v2 = 1'b0;
    chk("m2_start", 8'(start2), 8'd1);
    step();
    chk("m2_we_e1", 8'(we2), 8'd0);
    chk("m2_busy_e1", 8'(busy2), 8'd1);
    step();
    chk("m2_we_e2", 8'(we2), 8'd1);
    step();
    chk("m2_we_e3", 8'(we2), 8'd0);
    chk("m2_busy_e3", 8'(busy2), 8'd0);

    while (expq.size() != 0) begin
      chk("hilo_we_missing", 8'(expq.pop_front() & 0), 8'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
